// File: rtl/fp_exec_unit.sv
// fp_exec_unit
//   Multi-cycle single-precision FP execute stage feeding the FP register file.
//   Five-state pipeline-in-time: IDLE -> UNPACK -> ALIGN -> EXEC -> NORM -> IDLE.
//   Results are truncated (round toward zero). Denormal inputs and outputs are
//   treated as signed zero.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               issue strobe, only honoured in IDLE
//   fp_op               00 add, 01 sub, 10 mul, 11 mov
//   fs_data, ft_data    IEEE-754 single operands A and B
//   fd                  destination register index
//   busy                high while an operation is in flight
//   done, fp_reg_write  one-cycle write-back strobe
//   write_reg           fd latched at accept
//   write_data          result, held until the next done
//   flag_ov/uf/inv      exception flags, valid with done, cleared at next accept
module fp_exec_unit #(
  parameter bit LATENCY_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  fp_op,
  input  logic [31:0] fs_data,
  input  logic [31:0] ft_data,
  input  logic [4:0]  fd,
  output logic        busy,
  output logic        done,
  output logic        fp_reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        flag_ov,
  output logic        flag_uf,
  output logic        flag_inv
);

  localparam logic [1:0]  OP_SUB = 2'b01;
  localparam logic [1:0]  OP_MUL = 2'b10;
  localparam logic [1:0]  OP_MOV = 2'b11;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_EXEC, S_NORM} state_t;
  state_t state_reg;

  // Latched operation
  logic [31:0] opnd_reg [2];
  logic [1:0]  op_reg;

  // Unpacked operands (index 0 = A, 1 = B)
  logic [1:0]  sgn_reg, zero_reg, inf_reg, nan_reg;
  logic [7:0]  exp_reg [2];
  logic [23:0] man_reg [2];
  logic [1:0]  sgn_next, zero_next, inf_next, nan_next;
  logic [7:0]  exp_next [2];
  logic [23:0] man_next [2];

  // Aligned operands
  logic              big_sgn_reg, eff_sub_reg;
  logic [7:0]        big_exp_reg;
  logic [23:0]       big_man_reg, sml_man_reg;
  logic signed [9:0] mul_exp_reg;
  logic              big_sgn_next, eff_sub_next;
  logic [7:0]        big_exp_next;
  logic [23:0]       big_man_next, sml_man_next;
  logic signed [9:0] mul_exp_next;

  // Raw arithmetic results; the product keeps only bits [47:23]
  logic [24:0] sum_reg, sum_next;
  logic [24:0] prod_reg, prod_next;

  // Final result
  logic [31:0] res_next;
  logic        ov_next, uf_next, inv_next;

  logic accept;
  assign accept = (state_reg == S_IDLE) && start;

  // ---------------- UNPACK ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      logic [7:0]  e;
      logic [22:0] f;
      assign e             = opnd_reg[gi][30:23];
      assign f             = opnd_reg[gi][22:0];
      assign sgn_next[gi]  = opnd_reg[gi][31];
      assign zero_next[gi] = (e == 8'd0);          // zero and denormal alike
      assign inf_next[gi]  = (e == 8'hFF) && (f == 23'd0);
      assign nan_next[gi]  = (e == 8'hFF) && (f != 23'd0);
      assign exp_next[gi]  = e;
      assign man_next[gi]  = (e == 8'd0) ? 24'd0 : {1'b1, f};
    end
  endgenerate

  // ---------------- ALIGN ----------------
  logic        sb_eff;     // sign of B after folding in the subtract
  logic        a_ge;
  logic [7:0]  exp_diff;
  logic [23:0] sml_raw;

  always_comb begin
    sb_eff       = sgn_reg[1] ^ (op_reg == OP_SUB);
    // Magnitude compare on {exp, mantissa} orders the operands without a subtract
    a_ge         = {exp_reg[0], man_reg[0]} >= {exp_reg[1], man_reg[1]};
    big_sgn_next = a_ge ? sgn_reg[0] : sb_eff;
    eff_sub_next = sgn_reg[0] ^ sb_eff;
    big_exp_next = a_ge ? exp_reg[0] : exp_reg[1];
    big_man_next = a_ge ? man_reg[0] : man_reg[1];
    sml_raw      = a_ge ? man_reg[1] : man_reg[0];
    exp_diff     = a_ge ? (exp_reg[0] - exp_reg[1]) : (exp_reg[1] - exp_reg[0]);
    sml_man_next = (exp_diff >= 8'd26) ? 24'd0 : (sml_raw >> exp_diff);
    mul_exp_next = $signed({2'b00, exp_reg[0]}) + $signed({2'b00, exp_reg[1]}) - 10'sd127;
  end

  // ---------------- EXEC ----------------
  logic [47:0] prod_full;
  logic        unused_bits;

  always_comb begin
    // Larger magnitude is always on the left, so the difference never goes negative
    sum_next  = eff_sub_reg ? ({1'b0, big_man_reg} - {1'b0, sml_man_reg})
                            : ({1'b0, big_man_reg} + {1'b0, sml_man_reg});
    prod_full = {24'd0, man_reg[0]} * {24'd0, man_reg[1]};
    prod_next = prod_full[47:23];
  end

  // ---------------- NORM ----------------
  function automatic logic [33:0] pack_result(input logic s,
                                              input logic signed [9:0] e,
                                              input logic [22:0] m);
    // {ov, uf, ieee}
    if (e >= 10'sd255)     pack_result = {2'b10, s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)  pack_result = {2'b01, s, 31'd0};
    else                   pack_result = {2'b00, s, e[7:0], m};
  endfunction

  logic [4:0]        lead;
  logic [4:0]        norm_sh;
  logic [23:0]       sum_shl;
  logic [22:0]       add_man, mul_man;
  logic signed [9:0] add_exp, mul_exp;
  logic [33:0]       packed_res;
  logic              mul_sgn;

  assign unused_bits = ^{prod_full[22:0], sum_shl[23]};

  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < 25; i++) begin
      if (sum_reg[i]) lead = i[4:0];   // highest set bit wins
    end
    norm_sh = 5'd23 - lead;            // only used when no carry-out
    sum_shl = sum_reg[23:0] << norm_sh;
    if (sum_reg[24]) begin
      add_man = sum_reg[23:1];
      add_exp = $signed({2'b00, big_exp_reg}) + 10'sd1;
    end else begin
      add_man = sum_shl[22:0];
      add_exp = $signed({2'b00, big_exp_reg}) - $signed({5'd0, norm_sh});
    end

    // Product of two [1,2) mantissas lies in [1,4): at most one bit of shift
    if (prod_reg[24]) begin
      mul_man = prod_reg[23:1];
      mul_exp = mul_exp_reg + 10'sd1;
    end else begin
      mul_man = prod_reg[22:0];
      mul_exp = mul_exp_reg;
    end
    mul_sgn = sgn_reg[0] ^ sgn_reg[1];

    res_next   = 32'd0;
    ov_next    = 1'b0;
    uf_next    = 1'b0;
    inv_next   = 1'b0;
    packed_res = 34'd0;

    if (op_reg == OP_MOV) begin
      res_next = opnd_reg[0];
    end else if (|nan_reg) begin
      res_next = QNAN;
      inv_next = 1'b1;
    end else if (op_reg == OP_MUL) begin
      if ((|inf_reg) && (|zero_reg)) begin
        res_next = QNAN;
        inv_next = 1'b1;
      end else if (|inf_reg) begin
        res_next = {mul_sgn, 8'hFF, 23'd0};
      end else if (|zero_reg) begin
        res_next = {mul_sgn, 31'd0};
      end else begin
        packed_res = pack_result(mul_sgn, mul_exp, mul_man);
        {ov_next, uf_next, res_next} = packed_res;
      end
    end else begin
      if ((&inf_reg) && (sgn_reg[0] != sb_eff)) begin
        res_next = QNAN;
        inv_next = 1'b1;
      end else if (inf_reg[0]) begin
        res_next = {sgn_reg[0], 8'hFF, 23'd0};
      end else if (inf_reg[1]) begin
        res_next = {sb_eff, 8'hFF, 23'd0};
      end else if (sum_reg == 25'd0) begin
        res_next = 32'd0;
      end else begin
        packed_res = pack_result(big_sgn_reg, add_exp, add_man);
        {ov_next, uf_next, res_next} = packed_res;
      end
    end
  end

  // ---------------- Control FSM and all state ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      fp_reg_write <= 1'b0;
      write_reg    <= 5'd0;
      write_data   <= 32'd0;
      flag_ov      <= 1'b0;
      flag_uf      <= 1'b0;
      flag_inv     <= 1'b0;
      op_reg       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        opnd_reg[i] <= 32'd0;
        exp_reg[i]  <= 8'd0;
        man_reg[i]  <= 24'd0;
      end
      sgn_reg      <= 2'd0;
      zero_reg     <= 2'd0;
      inf_reg      <= 2'd0;
      nan_reg      <= 2'd0;
      big_sgn_reg  <= 1'b0;
      eff_sub_reg  <= 1'b0;
      big_exp_reg  <= 8'd0;
      big_man_reg  <= 24'd0;
      sml_man_reg  <= 24'd0;
      mul_exp_reg  <= 10'sd0;
      sum_reg      <= 25'd0;
      prod_reg     <= 25'd0;
    end else begin
      done         <= 1'b0;
      fp_reg_write <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            opnd_reg[0] <= fs_data;
            opnd_reg[1] <= ft_data;
            op_reg      <= fp_op;
            write_reg   <= fd;
            flag_ov     <= 1'b0;
            flag_uf     <= 1'b0;
            flag_inv    <= 1'b0;
            busy        <= 1'b1;
            state_reg   <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sgn_reg   <= sgn_next;
          zero_reg  <= zero_next;
          inf_reg   <= inf_next;
          nan_reg   <= nan_next;
          for (int i = 0; i < 2; i++) begin
            exp_reg[i] <= exp_next[i];
            man_reg[i] <= man_next[i];
          end
          state_reg <= S_ALIGN;
        end
        S_ALIGN: begin
          big_sgn_reg <= big_sgn_next;
          eff_sub_reg <= eff_sub_next;
          big_exp_reg <= big_exp_next;
          big_man_reg <= big_man_next;
          sml_man_reg <= sml_man_next;
          mul_exp_reg <= mul_exp_next;
          state_reg   <= S_EXEC;
        end
        S_EXEC: begin
          sum_reg   <= sum_next;
          prod_reg  <= prod_next;
          state_reg <= S_NORM;
        end
        S_NORM: begin
          write_data   <= res_next;
          flag_ov      <= ov_next;
          flag_uf      <= uf_next;
          flag_inv     <= inv_next;
          done         <= 1'b1;
          fp_reg_write <= 1'b1;
          busy         <= 1'b0;
          state_reg    <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Accept at edge N must show done in the cycle after edge N+4
  generate
    if (LATENCY_CHECK) begin : g_lat_chk
      logic [4:0] acc_pipe_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_pipe_reg <= 5'd0;
        else        acc_pipe_reg <= {acc_pipe_reg[3:0], accept};
      end
      always @(posedge clk) begin
        if (rst_n) assert (acc_pipe_reg[4] == done);
      end
    end
  endgenerate

endmodule

// File: tb/tb_fp_exec_unit.sv
module tb_fp_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  fp_op;
  logic [31:0] fs_data, ft_data;
  logic [4:0]  fd;
  logic        busy, done, fp_reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        flag_ov, flag_uf, flag_inv;

  fp_exec_unit #(.LATENCY_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fp_op(fp_op),
    .fs_data(fs_data), .ft_data(ft_data), .fd(fd),
    .busy(busy), .done(done), .fp_reg_write(fp_reg_write),
    .write_reg(write_reg), .write_data(write_data),
    .flag_ov(flag_ov), .flag_uf(flag_uf), .flag_inv(flag_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  fd;
    logic [31:0] want_data;
    logic [2:0]  want_flags;   // {ov, uf, inv}
  } vec_t;

  typedef struct {
    int   idx;
    int   issue_cyc;
  } pend_t;

  localparam int NV = 20;
  vec_t  vecs [NV];
  pend_t sb_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Scoreboard: every write-back must match the oldest outstanding issue
  always @(negedge clk) begin
    pend_t p;
    if (rst_n && (done || fp_reg_write)) begin
      chk("fp_reg_write_eq_done", {63'd0, fp_reg_write}, {63'd0, done});
      chk("done_one_cycle", {63'd0, done_prev}, 64'd0);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_writeback: reg %0d data %h", write_reg, write_data);
      end else begin
        p = sb_q.pop_front();
        chk($sformatf("v%0d_data", p.idx), {32'd0, write_data}, {32'd0, vecs[p.idx].want_data});
        chk($sformatf("v%0d_reg", p.idx), {59'd0, write_reg}, {59'd0, vecs[p.idx].fd});
        chk($sformatf("v%0d_flags", p.idx), {61'd0, flag_ov, flag_uf, flag_inv},
            {61'd0, vecs[p.idx].want_flags});
        chk($sformatf("v%0d_latency", p.idx), 64'(cyc - p.issue_cyc), 64'd5);
        $display("[TB] op v%0d fp_op=%b a=%h b=%h -> reg %0d data %h flags %b",
                 p.idx, vecs[p.idx].op, vecs[p.idx].a, vecs[p.idx].b,
                 write_reg, write_data, {flag_ov, flag_uf, flag_inv});
      end
    end
    done_prev = done;
  end

  // Call at a negedge; returns at the negedge after the accepting edge
  task automatic drive(input int idx);
    pend_t p;
    fs_data = vecs[idx].a;
    ft_data = vecs[idx].b;
    fp_op   = vecs[idx].op;
    fd      = vecs[idx].fd;
    start   = 1'b1;
    p.idx = idx;
    p.issue_cyc = cyc;
    sb_q.push_back(p);
    @(negedge clk);
    start   = 1'b0;
    fs_data = $urandom;
    ft_data = $urandom;
    fd      = 5'($urandom);
    chk($sformatf("v%0d_busy_after_accept", idx), {63'd0, busy}, 64'd1);
    chk($sformatf("v%0d_flags_cleared", idx), {61'd0, flag_ov, flag_uf, flag_inv}, 64'd0);
    chk($sformatf("v%0d_fd_latched", idx), {59'd0, write_reg}, {59'd0, vecs[idx].fd});
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: done not seen within 8 cycles");
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{2'b00, 32'h3FC00000, 32'h40100000, 5'd3,  32'h40700000, 3'b000};
    vecs[1]  = '{2'b10, 32'h40400000, 32'hC0000000, 5'd7,  32'hC0C00000, 3'b000};
    vecs[2]  = '{2'b01, 32'h40A00000, 32'h40A00000, 5'd9,  32'h00000000, 3'b000};
    vecs[3]  = '{2'b11, 32'h7FC01234, 32'h12345678, 5'd31, 32'h7FC01234, 3'b000};
    vecs[4]  = '{2'b00, 32'h7F800000, 32'hFF800000, 5'd1,  32'h7FC00000, 3'b001};
    vecs[5]  = '{2'b10, 32'h7F000000, 32'h40000000, 5'd2,  32'h7F800000, 3'b100};
    vecs[6]  = '{2'b10, 32'h00800000, 32'h00800000, 5'd4,  32'h00000000, 3'b010};
    vecs[7]  = '{2'b01, 32'h3F800000, 32'h40000000, 5'd5,  32'hBF800000, 3'b000};
    vecs[8]  = '{2'b10, 32'h7F800001, 32'h3F800000, 5'd6,  32'h7FC00000, 3'b001};
    vecs[9]  = '{2'b10, 32'hFF800000, 32'h40000000, 5'd8,  32'hFF800000, 3'b000};
    vecs[10] = '{2'b10, 32'h80000000, 32'h40400000, 5'd10, 32'h80000000, 3'b000};
    vecs[11] = '{2'b10, 32'h7F800000, 32'h00000000, 5'd11, 32'h7FC00000, 3'b001};
    vecs[12] = '{2'b00, 32'h3F800000, 32'h3F800000, 5'd12, 32'h40000000, 3'b000};
    vecs[13] = '{2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd13, 32'h7F800000, 3'b100};
    vecs[14] = '{2'b01, 32'h00C00000, 32'h00800000, 5'd14, 32'h00000000, 3'b010};
    vecs[15] = '{2'b00, 32'h00000001, 32'h3F800000, 5'd15, 32'h3F800000, 3'b000};
    vecs[16] = '{2'b00, 32'h3F800000, 32'h32800000, 5'd16, 32'h3F800000, 3'b000};
    vecs[17] = '{2'b01, 32'h3F800000, 32'h3F000000, 5'd17, 32'h3F000000, 3'b000};
    vecs[18] = '{2'b01, 32'h7F800000, 32'h7F800000, 5'd18, 32'h7FC00000, 3'b001};
    vecs[19] = '{2'b11, 32'hFF800000, 32'h00000000, 5'd19, 32'hFF800000, 3'b000};

    rst_n   = 1'b0;
    start   = 1'b0;
    fp_op   = 2'b00;
    fs_data = 32'd0;
    ft_data = 32'd0;
    fd      = 5'd0;

    repeat (3) @(negedge clk);
    chk("in_reset_outputs", {23'd0, busy, done, fp_reg_write, write_reg, write_data,
                             flag_ov, flag_uf, flag_inv}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle_outputs_c%0d", i), {23'd0, busy, done, fp_reg_write, write_reg,
                                              write_data, flag_ov, flag_uf, flag_inv}, 64'd0);
    end

    // Table of vectors, issued back to back in the done cycle of the previous one
    for (int i = 0; i < NV; i++) begin
      drive(i);
      wait_done();
    end

    // A second start two cycles into an operation must be ignored
    drive(0);
    @(negedge clk);
    fs_data = vecs[1].a;
    ft_data = vecs[1].b;
    fp_op   = vecs[1].op;
    fd      = 5'd30;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    chk("ignored_start_busy", {63'd0, busy}, 64'd1);
    chk("ignored_start_fd", {59'd0, write_reg}, {59'd0, vecs[0].fd});
    wait_done();
    repeat (8) @(negedge clk);
    chk("ignored_start_held_data", {32'd0, write_data}, {32'd0, vecs[0].want_data});
    chk("ignored_start_held_reg", {59'd0, write_reg}, {59'd0, vecs[0].fd});
    chk("ignored_start_idle", {62'd0, busy, done}, 64'd0);

    // Asynchronous reset while in EXEC discards the operation
    drive(1);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_mid_op_busy", {63'd0, busy}, 64'd0);
    chk("reset_mid_op_outputs", {24'd0, done, fp_reg_write, write_reg, write_data,
                                 flag_ov, flag_uf, flag_inv}, 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("after_reset_no_writeback", {22'd0, busy, done, fp_reg_write, write_reg, write_data,
                                     flag_ov, flag_uf, flag_inv}, 64'd0);
    drive(13);
    wait_done();
    @(negedge clk);
    chk("final_pulse_ended", {62'd0, done, fp_reg_write}, 64'd0);
    chk("final_outstanding", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
